bus_req_arbiter: RTL and testbench

- Shares one bus-request queue between NREQ cache controllers. Each controller issues 4-bit coherence requests (BusRd/BusRdX/BusUpgr/flush encodings).
- A round-robin arbiter accepts at most one request per cycle into an internal synchronous FIFO. The snoop bus drains the FIFO through a valid/ready port.
- Sits between the per-core cache controllers and the shared snoop bus.

---
 rtl/bus_req_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bus_req_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter feeding a shared fall-through request FIFO toward the snoop bus.
// Optional per-requester saturating grant counters: define BUS_ARB_GRANT_CNT_EN.
module bus_req_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(NREQ)-1:0] out_id,
    input  logic                    out_ready,
    output logic [DEPTH_LOG2:0]     q_count,
    output logic                    q_full,
    output logic                    q_empty
`ifdef BUS_ARB_GRANT_CNT_EN
    ,
    input  logic                    cnt_clr,
    output logic [NREQ*8-1:0]       grant_cnt
`endif
);

    localparam int IDW   = $clog2(NREQ);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [IDW-1:0]        id_t;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    cnt_t            count_q,  count_d;
    id_t             rr_last_q, rr_last_d;

    logic [DW-1:0]   mem_data_q [DEPTH];
    id_t             mem_id_q   [DEPTH];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic            grant_any;
    id_t             grant_idx;
    logic [DW-1:0]   push_data;
    logic            push;
    logic            pop;

    assign q_full  = (count_q == cnt_t'(DEPTH));
    assign q_empty = (count_q == '0);

    // NOTE: every variable assigned in always_comb gets a default first,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        // Search upward from the requester after the last winner; the
        // reset gate keeps a held request from looking accepted in reset.
        if (!q_full && rst_n) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!grant_any && req_valid[(int'(rr_last_q) + k) % NREQ]) begin
                    grant_any = 1'b1;
                    grant_idx = id_t'((int'(rr_last_q) + k) % NREQ);
                end
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign push_data = req_data[int'(grant_idx)*DW +: DW];
    assign push      = grant_any;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rr_last_d = rr_last_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + ptr_t'(1);
            rr_last_d = grant_idx;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_last_q <= id_t'(NREQ - 1);
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_last_q <= rr_last_d;
        end
    end

    // NOTE: storage is left unreset; occupancy is tracked by count_q, so
    // stale contents are never observed and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_id_q[wr_ptr_q]   <= grant_idx;
        end
    end

    assign out_valid = !q_empty;
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_id    = mem_id_q[rd_ptr_q];
    assign q_count   = count_q;

`ifdef BUS_ARB_GRANT_CNT_EN
    // ------------------------------------------------------------------
    // Per-requester saturating grant counters
    // ------------------------------------------------------------------
    logic [7:0] gcnt_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else if (cnt_clr) begin
            // Clear wins over a same-cycle accept.
            for (int i = 0; i < NREQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else if (push && gcnt_q[grant_idx] != 8'hFF) begin
            gcnt_q[grant_idx] <= gcnt_q[grant_idx] + 8'd1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*8 +: 8] = gcnt_q[i];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= cnt_t'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        q_full |-> !push);

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Self-checking bench for bus_req_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbitration and FIFO rules.
module tb_bus_req_arbiter;

    localparam int NREQ       = 4;
    localparam int DW         = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [1:0]           out_id;
    logic                 out_ready;
    logic [DEPTH_LOG2:0]  q_count;
    logic                 q_full;
    logic                 q_empty;
    logic                 cnt_clr;
`ifdef BUS_ARB_GRANT_CNT_EN
    logic [NREQ*8-1:0]    grant_cnt;
`endif

    bus_req_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .q_count   (q_count),
        .q_full    (q_full),
        .q_empty   (q_empty)
`ifdef BUS_ARB_GRANT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the queue contents in order, plus the last winner.
    typedef struct {
        int id;
        int data;
    } entry_t;

    entry_t mq[$];
    int     rr_last;
    int     last_grant;
    int     pass_cnt  = 0;
    int     total_cnt = 0;

    function automatic int exp_grant_idx();
        if (mq.size() >= DEPTH) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int c = (rr_last + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r = '0;
        int g = exp_grant_idx();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock edge and apply the same transfer to the model.
    task automatic tick();
        int     g;
        bit     do_pop;
        entry_t e;
        g      = exp_grant_idx();
        do_pop = (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (g >= 0) begin
            e.id   = g;
            e.data = int'(req_data[g*DW +: DW]);
            mq.push_back(e);
            rr_last = g;
        end
        last_grant = g;
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        rr_last    = NREQ - 1;
        last_grant = -1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = 16'h4321;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (q_count !== 3'd0) $display("FAIL reset_q_count: got %0d want 0", q_count);
        else pass_cnt++;
        total_cnt++;
        if (q_empty !== 1'b1 || q_full !== 1'b0)
            $display("FAIL reset_flags: got empty=%0b full=%0b want 1/0", q_empty, q_full);
        else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0100;
        req_data  = 16'h0A00;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", req_ready);
        else pass_cnt++;
        tick();
        req_valid = '0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_id !== 2'd2 || q_count !== 3'd1)
            $display("FAIL single_head: got v=%0b d=%h id=%0d cnt=%0d want 1/a/2/1",
                     out_valid, out_data, out_id, q_count);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        apply_reset();
        req_valid = 4'b1111;
        req_data  = {4'd4, 4'd3, 4'd2, 4'd1};
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            want = 4'b0001 << (k % 4);
            total_cnt++;
            if (req_ready !== want) $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, want);
            else pass_cnt++;
            total_cnt++;
            if (q_count > 3'd1) $display("FAIL rr_count[%0d]: got %0d want <=1", k, q_count);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if (out_id !== 2'((k - 1) % 4) || out_data !== 4'(((k - 1) % 4) + 1))
                    $display("FAIL rr_head[%0d]: got id=%0d d=%0d want id=%0d d=%0d",
                             k, out_id, out_data, (k - 1) % 4, ((k - 1) % 4) + 1);
                else pass_cnt++;
            end
            tick();
        end
        req_valid = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        apply_reset();
        req_valid = 4'b1111;
        req_data  = 16'($urandom);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total_cnt++;
            if (req_ready !== exp_ready()) $display("FAIL fill_grant[%0d]: got %b want %b", k, req_ready, exp_ready());
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if (q_full !== 1'b1 || req_ready !== 4'b0000 || q_count !== 3'd4)
            $display("FAIL full_state: got full=%0b rdy=%b cnt=%0d want 1/0000/4", q_full, req_ready, q_count);
        else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL full_pop_noaccept: got %b want 0000", req_ready);
        else pass_cnt++;
        tick();
        out_ready = 1'b0;
        #1;
        total_cnt++;
        if (q_count !== 3'd3 || req_ready !== 4'b0001)
            $display("FAIL after_pop: got cnt=%0d rdy=%b want 3/0001", q_count, req_ready);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (q_count !== 3'd4 || out_id !== 2'd1)
            $display("FAIL refill: got cnt=%0d head=%0d want 4/1", q_count, out_id);
        else pass_cnt++;
        req_valid = '0;
    endtask

    task automatic test_push_pop();
        apply_reset();
        req_valid = 4'b0001;
        req_data  = 16'h0005;
        tick();
        req_valid = 4'b0010;
        req_data  = 16'h00C0;
        tick();
        req_valid = 4'b0100;
        req_data  = 16'h0300;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (q_count !== 3'd2 || out_data !== 4'h5)
            $display("FAIL pp_before: got cnt=%0d d=%h want 2/5", q_count, out_data);
        else pass_cnt++;
        tick();
        req_valid = '0;
        out_ready = 1'b0;
        #1;
        total_cnt++;
        if (q_count !== 3'd2 || out_data !== 4'hC || out_id !== 2'd1)
            $display("FAIL pp_after: got cnt=%0d d=%h id=%0d want 2/c/1", q_count, out_data, out_id);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_valid = 4'b1111;
        req_data  = 16'h9876;
        repeat (3) tick();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || q_count !== 3'd0 || q_empty !== 1'b1)
            $display("FAIL async_reset: got v=%0b cnt=%0d empty=%0b want 0/0/1", out_valid, q_count, q_empty);
        else pass_cnt++;
        mq.delete();
        rr_last = NREQ - 1;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        #1;
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL post_reset_tie: got %b want 0001", req_ready);
        else pass_cnt++;
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*DW +: DW]  = 4'($urandom);
                end
            end
            // Alternate between drain-heavy and backpressure-heavy phases.
            out_ready = ((cyc / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            #1;
            total_cnt++;
            if (req_ready !== exp_ready()) $display("FAIL rnd_grant[%0d]: got %b want %b", cyc, req_ready, exp_ready());
            else pass_cnt++;
            total_cnt++;
            if (q_count !== 3'(mq.size()) || out_valid !== (mq.size() > 0) ||
                q_full !== (mq.size() == DEPTH) || q_empty !== (mq.size() == 0))
                $display("FAIL rnd_occ[%0d]: got cnt=%0d v=%0b f=%0b e=%0b want cnt=%0d",
                         cyc, q_count, out_valid, q_full, q_empty, mq.size());
            else pass_cnt++;
            if (mq.size() > 0) begin
                total_cnt++;
                if (out_id !== 2'(mq[0].id) || out_data !== 4'(mq[0].data))
                    $display("FAIL rnd_head[%0d]: got id=%0d d=%h want id=%0d d=%h",
                             cyc, out_id, out_data, mq[0].id, mq[0].data);
                else pass_cnt++;
            end
            tick();
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        end
        req_valid = '0;
        out_ready = 1'b0;
    endtask

`ifdef BUS_ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        apply_reset();
        req_valid = 4'b0010;
        req_data  = 16'h0070;
        out_ready = 1'b1;
        repeat (300) tick();
        #1;
        total_cnt++;
        if (grant_cnt[15:8] !== 8'd255 || grant_cnt[7:0] !== 8'd0)
            $display("FAIL gcnt_sat: got r1=%0d r0=%0d want 255/0", grant_cnt[15:8], grant_cnt[7:0]);
        else pass_cnt++;
        cnt_clr = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        req_valid = '0;
        #1;
        total_cnt++;
        if (grant_cnt !== '0) $display("FAIL gcnt_clr: got %h want 0", grant_cnt);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_push_pop();
        test_async_reset();
        test_random();
`ifdef BUS_ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
